// File: rtl/sar_adc_ctrl_if.sv
// Signal bundle between the SAR controller and its analog front-end / digital consumer.
// master = controller side, slave = environment (comparator, mux, result sink).
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             start;
  logic [CHW-1:0]   ch_sel;
  logic             cont;
  logic             cmp_in;
  logic             sample;
  logic [CHW-1:0]   mux_sel;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] data_out;
  logic [CHW-1:0]   data_ch;

  modport master (
    input  start, ch_sel, cont, cmp_in,
    output sample, mux_sel, dac_code, busy, valid, data_out, data_ch
  );

  modport slave (
    output start, ch_sel, cont, cmp_in,
    input  sample, mux_sel, dac_code, busy, valid, data_out, data_ch
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track/hold, binary DAC search, single-shot or scan.
// Optional macro SAR_CMP_SYNC_EN adds a 2-flop comparator synchronizer and stretches each bit phase by 2.
module sar_adc_ctrl #(
  parameter int WIDTH      = 8,
  parameter int NCH        = 4,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE     = 2
) (
  input  logic          clk,
  input  logic          rst,
  sar_adc_ctrl_if.master bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW  = $clog2(WIDTH);
`ifdef SAR_CMP_SYNC_EN
  localparam int PHASE_CYC = SETTLE + 2;
`else
  localparam int PHASE_CYC = SETTLE;
`endif
  localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_DONE} state_t;

  state_t           state;
  logic [15:0]      cnt;
  logic [IW-1:0]    bit_i;
  logic             cmp_bit;
  logic [WIDTH-1:0] resolved;
  logic [WIDTH-1:0] next_trial;

  function automatic logic [CHW-1:0] clamp_ch(input logic [CHW-1:0] ch);
    return (int'(ch) >= NCH) ? '0 : ch;
  endfunction

  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] ch);
    return (int'(ch) >= NCH - 1) ? '0 : ch + CHW'(1);
  endfunction

`ifdef SAR_CMP_SYNC_EN
  logic cmp_p0, cmp_p1;

  // comparator synchronizer stages
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_p0 <= 1'b0;
      cmp_p1 <= 1'b0;
    end else begin
      cmp_p0 <= bus.cmp_in;
      cmp_p1 <= cmp_p0;
    end
  end

  assign cmp_bit = cmp_p1;
`else
  assign cmp_bit = bus.cmp_in;
`endif

  // Trial bit kept or dropped, then the next lower bit raised for its own trial.
  always_comb begin
    resolved = bus.dac_code;
    if (!cmp_bit) resolved[bit_i] = 1'b0;
    next_trial = resolved;
    if (bit_i != '0) next_trial[bit_i - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_i        <= '0;
      bus.sample   <= 1'b0;
      bus.mux_sel  <= '0;
      bus.dac_code <= '0;
      bus.busy     <= 1'b0;
      bus.valid    <= 1'b0;
      bus.data_out <= '0;
      bus.data_ch  <= '0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.mux_sel  <= clamp_ch(bus.ch_sel);
            bus.sample   <= 1'b1;
            bus.busy     <= 1'b1;
            bus.dac_code <= '0;
            cnt          <= '0;
            state        <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (cnt == 16'(SAMPLE_CYC - 1)) begin
            bus.sample   <= 1'b0;
            bit_i        <= IW'(WIDTH - 1);
            bus.dac_code <= MSB_CODE;
            cnt          <= '0;
            state        <= S_CONVERT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_CONVERT: begin
          if (cnt == 16'(PHASE_CYC - 1)) begin
            cnt <= '0;
            if (bit_i == '0) begin
              bus.dac_code <= resolved;
              bus.data_out <= resolved;
              bus.data_ch  <= bus.mux_sel;
              bus.valid    <= 1'b1;
              state        <= S_DONE;
            end else begin
              bus.dac_code <= next_trial;
              bit_i        <= bit_i - 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          // scan continues straight into the next channel's track phase
          if (bus.cont) begin
            bus.mux_sel  <= next_ch(bus.mux_sel);
            bus.sample   <= 1'b1;
            bus.dac_code <= '0;
            cnt          <= '0;
            state        <= S_SAMPLE;
          end else begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Parametrised successive-approximation ADC controller for the analog tile.
- Drives the track/hold switch, the input mux select and the binary capacitive-DAC code, then reads back the external analog comparator.
- Supports single-shot conversion on a chosen channel and continuous round-robin scan across NCH channels.
- Results are presented with a one-cycle valid strobe to the digital side (uo_out/uio paths).

Parameters:
- WIDTH, 8, resolution in bits; DAC code and result width (2..16).
- NCH, 4, number of analog input channels (1..16).
- SAMPLE_CYC, 4, track/hold sampling duration in clk cycles (>=1).
- SETTLE, 2, clk cycles per bit trial for DAC/comparator settling (>=1).
- CHW (localparam), max(1,$clog2(NCH)), channel index width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a conversion; sampled only in IDLE.
- ch_sel  input  CHW  channel for single-shot, and start channel for scan.
- cont  input  1  scan mode enable; sampled at start and at each DONE.
- cmp_in  input  1  comparator output: 1 = Vin >= Vdac.
- sample  output  1  track/hold switch; high while tracking.
- mux_sel  output  CHW  analog mux channel select.
- dac_code  output  WIDTH  capacitive DAC trial code.
- busy  output  1  high from the accepted start until DONE completes.
- valid  output  1  one-cycle result strobe.
- data_out  output  WIDTH  conversion result; held until the next valid.
- data_ch  output  CHW  channel of data_out.

Behaviour:
- Reset (rst high at an edge): all state is cleared at that edge. FSM=IDLE; sample=0, mux_sel=0, dac_code=0, busy=0, valid=0, data_out=0, data_ch=0.
- Reset has priority over every other input, including mid-conversion. An aborted conversion never asserts valid.
- States: IDLE -> SAMPLE -> CONVERT -> DONE -> (IDLE | SAMPLE).
- IDLE:
  - start=1 at edge k: mux_sel <= ch_sel, with ch_sel >= NCH clamped to 0.
  - Same edge: sample <= 1, busy <= 1, dac_code <= 0.
  - start in any other state is ignored; it is not queued.
- SAMPLE:
  - sample held high for exactly SAMPLE_CYC cycles (cycles k+1..k+SAMPLE_CYC).
  - On exit: sample <= 0, bit index i <= WIDTH-1, dac_code <= result register | (1<<(WIDTH-1)).
- CONVERT:
  - Each bit phase lasts SETTLE cycles.
  - On the last cycle of a phase, cmp_in is sampled. 1 keeps bit i; 0 clears bit i.
  - If i>0: set bit i-1 in dac_code, decrement i.
  - After bit 0 is resolved: go to DONE.
  - Higher bits already resolved are never altered.
- DONE (one cycle):
  - valid=1, data_out=final code, data_ch=converted channel, dac_code=final code.
  - valid is asserted in cycle k+1+SAMPLE_CYC+WIDTH*SETTLE.
- After DONE:
  - cont=1: mux_sel <= (mux_sel==NCH-1) ? 0 : mux_sel+1; re-enter SAMPLE directly. busy pulses low for 0 cycles (stays high).
  - cont=0: go to IDLE, busy <= 0. start may be accepted on the first IDLE cycle.
  - Dropping cont mid-conversion completes the current conversion, then idles.
- NCH=1: scan repeatedly converts channel 0.
- Result width is exactly WIDTH bits. No arithmetic beyond bit set/clear and the channel increment.

Optional Feature:
- Macro: SAR_CMP_SYNC_EN.
- Defined:
  - cmp_in passes through a 2-flop synchronizer, reset to 0 by rst.
  - Each bit phase lengthens to SETTLE+2 cycles; the synchronized value is sampled on the last cycle.
  - valid lands at cycle k+1+SAMPLE_CYC+WIDTH*(SETTLE+2).
- Undefined:
  - cmp_in is used directly, for a comparator already registered in the clk domain.
  - Timing is as in Behaviour.

Test Plan:
- Defaults; comparator model cmp_in=(0xA5>=dac_code); start pulse, ch_sel=2 -> sample high 4 cycles, mux_sel=2, valid exactly 21 cycles after start edge, data_out=0xA5, data_ch=2, busy low the next cycle.
- Vin code 0x00, then 0xFF -> data_out=0x00 (every trial bit cleared), then 0xFF (every trial bit kept). dac_code sequence for 0x00: 0x80,0x40,...,0x01.
- Scan: cont=1, ch_sel=3, per-channel vin {0x10,0x20,0x30,0x40} -> results 0x40(ch3),0x10(ch0),0x20(ch1),0x30(ch2) at 21-cycle spacing. Clear cont mid-conversion -> that conversion completes, then IDLE.
- start re-pulsed during CONVERT and ch_sel=7 with NCH=4 (CHW=2 clamps 3 bits? use NCH=5, ch_sel=6) -> extra start ignored; out-of-range channel converts as ch 0.
- rst asserted 10 cycles into a conversion -> next edge: all outputs 0, no valid. A new start converts correctly with latency 21.
- SAR_CMP_SYNC_EN defined, vin 0xA5 -> data_out=0xA5 with valid at 37 cycles; rst clears the synchronizer flops.
